// File: rtl/synth_pkg.sv
// synth_pkg: shared waveform ids, select-FSM states and constant helpers for the DDS oscillator.
package synth_pkg;
    typedef enum logic [1:0] {
        WAVE_SINE = 2'd0,
        WAVE_TRI  = 2'd1,
        WAVE_SQR  = 2'd2,
        WAVE_SAW  = 2'd3
    } wave_e;

    typedef enum logic {
        SEL_IDLE,
        SEL_PENDING
    } sel_state_e;

    function automatic int midscale(input int ow);
        return 1 << (ow - 1);
    endfunction

    // First quadrant of a sine scaled to 0..midscale-1; entry 0 is exactly zero.
    function automatic int qsine(input int i, input int aw, input int ow);
        real a;
        a = 3.141592653589793 * $itor(i) / (2.0 * $itor(1 << aw));
        return $rtoi($itor((1 << (ow - 1)) - 1) * $sin(a) + 0.5);
    endfunction
endpackage

// File: rtl/sine_qrom.sv
// sine_qrom: quarter-wave sine ROM with a registered read, contents computed at elaboration.
module sine_qrom
    import synth_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [OUT_W-2:0]  data
);
    logic [OUT_W-2:0] w_rom [2**LUT_AW];
    logic [OUT_W-2:0] r_data;

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        assign w_rom[i] = (OUT_W-1)'(qsine(i, LUT_AW, OUT_W));
    end

    always_ff @(posedge clk) r_data <= w_rom[addr];

    assign data = r_data;
endmodule

// File: rtl/dds_wave_osc.sv
// dds_wave_osc: phase-accumulator oscillator producing sine/triangle/square/saw samples
// for an R2R DAC, with waveform changes deferred to the next phase wrap.
module dds_wave_osc
    import synth_pkg::*;
#(
    parameter int PHASE_W    = 24,
    parameter int OUT_W      = 8,
    parameter int LUT_AW     = 8,
    parameter int FTW_W      = 11,
    parameter int SAMPLE_DIV = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sel,
    input  logic [FTW_W-1:0] ftw,
    input  logic [1:0]       octave,
    input  logic [OUT_W-1:0] duty,
    output logic [OUT_W-1:0] wav,
    output logic [1:0]       wav_id,
    output logic             sample_stb,
    output logic             wrap
);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int IDX_W = LUT_AW + 2;
    localparam logic [OUT_W-1:0] MID = OUT_W'(midscale(OUT_W));

    logic [DIV_W-1:0]   r_div;
    logic [PHASE_W-1:0] r_phase;
    logic               r_wrap;
    logic               r_en_d;
    logic [2:0]         r_sel_s;
    sel_state_e         r_state;
    wave_e              r_wav_id;
    logic [OUT_W-1:0]   r_wav;

    logic               w_stb;
    logic [PHASE_W-1:0] w_inc;
    logic [PHASE_W:0]   w_sum;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic [LUT_AW-1:0]  w_addr;
    logic [OUT_W-2:0]   w_rom;
    logic [IDX_W-1:0]   w_idx;
    logic [OUT_W-1:0]   w_top;
    logic [LUT_AW:0]    w_half;
    logic [OUT_W-1:0]   w_sine;
    logic [OUT_W-1:0]   w_tri;
    logic [OUT_W-1:0]   w_shape;
    logic               w_edge;
    logic               w_adv;
    wave_e              w_id_nxt;

    assign w_stb       = r_div == DIV_W'(SAMPLE_DIV - 1);
    assign w_inc       = PHASE_W'({{PHASE_W{1'b0}}, ftw} << octave);
    assign w_sum       = {1'b0, r_phase} + {1'b0, w_inc};
    assign w_phase_nxt = (w_stb && en) ? w_sum[PHASE_W-1:0] : r_phase;

    // ROM is addressed from the next phase so its registered data lines up with r_phase.
    assign w_addr = w_phase_nxt[PHASE_W-2] ? ~w_phase_nxt[PHASE_W-3 -: LUT_AW]
                                           :  w_phase_nxt[PHASE_W-3 -: LUT_AW];

    sine_qrom #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_qrom (
        .clk  (clk),
        .addr (w_addr),
        .data (w_rom)
    );

    assign w_idx  = r_phase[PHASE_W-1 -: IDX_W];
    assign w_top  = r_phase[PHASE_W-1 -: OUT_W];
    assign w_half = w_idx[LUT_AW+1] ? ~w_idx[LUT_AW:0] : w_idx[LUT_AW:0];
    assign w_sine = w_idx[LUT_AW+1] ? (MID - OUT_W'(1) - {1'b0, w_rom}) : (MID + {1'b0, w_rom});
    // Repeating the half-period ramp fills the low bits so the peak reaches all-ones.
    assign w_tri  = OUT_W'({w_half, w_half} >> (2 * (LUT_AW + 1) - OUT_W));

    assign w_edge   = r_sel_s[1] & ~r_sel_s[2];
    assign w_adv    = (r_state == SEL_PENDING) ? (r_wrap | ~en) : (w_edge & r_wrap);
    assign w_id_nxt = wave_e'(r_wav_id + {1'b0, w_adv});

    // Using the next id lets the first post-wrap sample already carry the new waveform.
    assign w_shape = (w_id_nxt == WAVE_SINE) ? w_sine :
                     (w_id_nxt == WAVE_TRI)  ? w_tri  :
                     (w_id_nxt == WAVE_SQR)  ? {OUT_W{w_top < duty}} : w_top;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div   <= '0;
            r_phase <= '0;
            r_wrap  <= 1'b0;
            r_en_d  <= 1'b0;
            r_sel_s <= '0;
            r_wav   <= MID;
        end else begin
            r_div   <= w_stb ? '0 : r_div + DIV_W'(1);
            r_phase <= w_phase_nxt;
            r_wrap  <= w_stb & en & w_sum[PHASE_W];
            r_en_d  <= en;
            r_sel_s <= {r_sel_s[1:0], sel};
            r_wav   <= r_en_d ? w_shape : MID;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= SEL_IDLE;
            r_wav_id <= WAVE_SINE;
        end else begin
            r_state  <= w_adv ? SEL_IDLE : (w_edge ? SEL_PENDING : r_state);
            r_wav_id <= w_id_nxt;
        end
    end

    assign wav        = r_wav;
    assign wav_id     = r_wav_id;
    assign sample_stb = w_stb;
    assign wrap       = r_wrap;
endmodule
